gpu_cmd_queue: RTL and testbench

- Command front-end for the GPU draw/clear engine.
- Buffers DRAW, CLEAR and WAIT_VSYNC commands from the CPU bus bridge in a DEPTH-entry FIFO.
- Replays each command onto the GPU's level-held ctrl_* parameter bus with a one-cycle edge strobe, then waits for the GPU's busy to fall.
- Sits between the memory-mapped GPU register block and the GPU core, so the CPU never polls busy per draw.

---
 rtl/gpu_cmd_queue.sv | 209 ++++++++++++++++++++
 tb/tb_gpu_cmd_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_queue.sv
// GPU command front-end: buffers DRAW / CLEAR / WAIT_VSYNC commands and replays
// each onto the GPU's level-held ctrl_* bus followed by a one-cycle strobe.
module gpu_cmd_queue #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int DEPTH     = 8,
    localparam int XW = $clog2(FB_WIDTH) + 2,
    localparam int YW = $clog2(FB_HEIGHT) + 2,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [31:0]   cmd_address,
    input  logic [15:0]   cmd_address_x,
    input  logic [15:0]   cmd_address_y,
    input  logic [15:0]   cmd_image_width,
    input  logic [XW-1:0] cmd_width,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_height,
    input  logic [YW-1:0] cmd_y,
    input  logic [15:0]   cmd_clear_color,
    input  logic          flush,
    input  logic          vsync,
    input  logic          gpu_busy,
    output logic [31:0]   ctrl_address,
    output logic [15:0]   ctrl_address_x,
    output logic [15:0]   ctrl_address_y,
    output logic [15:0]   ctrl_image_width,
    output logic [XW-1:0] ctrl_width,
    output logic [YW-1:0] ctrl_height,
    output logic [XW-1:0] ctrl_x,
    output logic [YW-1:0] ctrl_y,
    output logic [15:0]   ctrl_clear_color,
    output logic          ctrl_draw,
    output logic          ctrl_clear,
    output logic [LW-1:0] level,
    output logic          idle
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [1:0]    OP_DRAW    = 2'd0;
    localparam logic [1:0]    OP_CLEAR   = 2'd1;
    localparam logic [1:0]    OP_VSYNC   = 2'd2;

    typedef struct packed {
        logic [1:0]    op;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [XW-1:0] width;
        logic [XW-1:0] x;
        logic [YW-1:0] height;
        logic [YW-1:0] y;
        logic [15:0]   clear_color;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_VSYNC = 3'd4
    } state_t;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_s, empty_s, push_s, pop_s;
    cmd_t          in_s, head_s, ctrl_q;
    state_t        state_q;
    logic          draw_q, clear_q, vsync_prev_q;

    assign in_s = '{op: cmd_op, address: cmd_address, address_x: cmd_address_x,
                    address_y: cmd_address_y, image_width: cmd_image_width,
                    width: cmd_width, x: cmd_x, height: cmd_height, y: cmd_y,
                    clear_color: cmd_clear_color};

    // A full FIFO refuses pushes even if the head pops in the same cycle.
    assign full_s  = (level_q == FULL_LEVEL);
    assign empty_s = (level_q == {LW{1'b0}});
    assign push_s  = cmd_valid && !full_s && !flush;
    assign pop_s   = (state_q == S_IDLE) && !empty_s && !gpu_busy;
    assign head_s  = mem_q[rd_ptr_q];

    // Command storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_s;
        end
    end

    // Next pointers and occupancy; flush discards everything, including this push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
                default: level_d = level_q;
            endcase
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Replay FSM: parameters change only on the pop, strobes last exactly one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ctrl_q       <= '0;
            draw_q       <= 1'b0;
            clear_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            draw_q       <= 1'b0;
            clear_q      <= 1'b0;
            vsync_prev_q <= vsync;
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        ctrl_q  <= head_s;
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    case (ctrl_q.op)
                        OP_DRAW: begin
                            draw_q  <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                        OP_CLEAR: begin
                            clear_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                        OP_VSYNC: state_q <= S_VSYNC;
                        default:  state_q <= S_IDLE;
                    endcase
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (!gpu_busy) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_VSYNC: begin
                    // only an edge seen while already waiting counts
                    if (vsync && !vsync_prev_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_VSYNC;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ctrl_address     = ctrl_q.address;
    assign ctrl_address_x   = ctrl_q.address_x;
    assign ctrl_address_y   = ctrl_q.address_y;
    assign ctrl_image_width = ctrl_q.image_width;
    assign ctrl_width       = ctrl_q.width;
    assign ctrl_height      = ctrl_q.height;
    assign ctrl_x           = ctrl_q.x;
    assign ctrl_y           = ctrl_q.y;
    assign ctrl_clear_color = ctrl_q.clear_color;
    assign ctrl_draw        = draw_q;
    assign ctrl_clear       = clear_q;
    assign level            = level_q;
    assign cmd_ready        = !full_s;
    assign idle             = empty_s && (state_q == S_IDLE) && !gpu_busy;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Randomised and directed bench for gpu_cmd_queue against a transaction-level
// model (command queue plus "cycles since pop" bookkeeping) and a simple GPU model.
module tb_gpu_cmd_queue;

    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 240;
    localparam int DEPTH     = 8;
    localparam int XW = $clog2(FB_WIDTH) + 2;
    localparam int YW = $clog2(FB_HEIGHT) + 2;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]    op;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [XW-1:0] width;
        logic [XW-1:0] x;
        logic [YW-1:0] height;
        logic [YW-1:0] y;
        logic [15:0]   clear_color;
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, flush, vsync, gpu_busy;
    cmd_t          cmd_in;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
    logic [XW-1:0] ctrl_width, ctrl_x;
    logic [YW-1:0] ctrl_height, ctrl_y;
    logic          ctrl_draw, ctrl_clear, idle;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    gpu_cmd_queue #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_in.op), .cmd_address(cmd_in.address),
        .cmd_address_x(cmd_in.address_x), .cmd_address_y(cmd_in.address_y),
        .cmd_image_width(cmd_in.image_width), .cmd_width(cmd_in.width),
        .cmd_x(cmd_in.x), .cmd_height(cmd_in.height), .cmd_y(cmd_in.y),
        .cmd_clear_color(cmd_in.clear_color), .flush(flush), .vsync(vsync),
        .gpu_busy(gpu_busy), .ctrl_address(ctrl_address),
        .ctrl_address_x(ctrl_address_x), .ctrl_address_y(ctrl_address_y),
        .ctrl_image_width(ctrl_image_width), .ctrl_width(ctrl_width),
        .ctrl_height(ctrl_height), .ctrl_x(ctrl_x), .ctrl_y(ctrl_y),
        .ctrl_clear_color(ctrl_clear_color), .ctrl_draw(ctrl_draw),
        .ctrl_clear(ctrl_clear), .level(level), .idle(idle)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_strobes = 0;

    // reference model state
    cmd_t m_q[$];
    bit   m_active;
    int   m_age;
    cmd_t m_cur;
    bit   m_prev_vs, m_draw, m_clear;
    int   gpu_cnt, gpu_len;
    bit   extra_busy;

    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active  = 1'b0;
        m_age     = 0;
        m_cur     = '0;
        m_prev_vs = 1'b0;
        m_draw    = 1'b0;
        m_clear   = 1'b0;
    endtask

    function automatic cmd_t rand_cmd(input logic [1:0] op);
        cmd_t c;
        c.op          = op;
        c.address     = $urandom;
        c.address_x   = 16'($urandom);
        c.address_y   = 16'($urandom);
        c.image_width = 16'($urandom);
        c.width       = XW'($urandom);
        c.x           = XW'($urandom);
        c.height      = YW'($urandom);
        c.y           = YW'($urandom);
        c.clear_color = 16'($urandom);
        return c;
    endfunction

    task automatic check_outputs();
        cmd_t g, e;
        g = '0;
        g.address     = ctrl_address;
        g.address_x   = ctrl_address_x;
        g.address_y   = ctrl_address_y;
        g.image_width = ctrl_image_width;
        g.width       = ctrl_width;
        g.x           = ctrl_x;
        g.height      = ctrl_height;
        g.y           = ctrl_y;
        g.clear_color = ctrl_clear_color;
        e = m_cur;
        e.op = 2'd0;
        check_val("level", level, m_q.size());
        check_val("cmd_ready", cmd_ready, m_q.size() < DEPTH);
        check_val("ctrl_draw", ctrl_draw, m_draw);
        check_val("ctrl_clear", ctrl_clear, m_clear);
        check_val("idle", idle, (m_q.size() == 0) && !m_active && !gpu_busy);
        check_val("ctrl_bus", g, e);
        if (ctrl_draw || ctrl_clear) n_strobes++;
    endtask

    // Advance the model across one rising edge, using the inputs the DUT will see.
    task automatic model_edge();
        bit   pop, room;
        pop  = !m_active && (m_q.size() > 0) && !gpu_busy;
        room = m_q.size() < DEPTH;
        m_draw  = 1'b0;
        m_clear = 1'b0;
        if (m_active) begin
            m_age++;
            case (m_cur.op)
                2'd0, 2'd1: begin
                    if (m_age == 1) begin
                        m_draw  = (m_cur.op == 2'd0);
                        m_clear = (m_cur.op == 2'd1);
                    end else if (m_age >= 3 && !gpu_busy) begin
                        m_active = 1'b0;
                    end
                end
                2'd2: if (m_age >= 2 && vsync && !m_prev_vs) m_active = 1'b0;
                default: if (m_age == 1) m_active = 1'b0;
            endcase
        end
        if (pop) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_age    = 0;
        end
        if (flush) m_q.delete();
        else if (cmd_valid && room) m_q.push_back(cmd_in);
        m_prev_vs = vsync;
    endtask

    // One clock: check at the falling edge, drive the GPU model, step the model, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        if (m_draw || m_clear) gpu_cnt = (gpu_len > 0) ? gpu_len : int'($urandom_range(1, 12));
        else if (gpu_cnt > 0) gpu_cnt--;
        gpu_busy = (gpu_cnt > 0) || extra_busy;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_in    = c;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && (m_active || m_q.size() > 0 || gpu_cnt > 0); i++) cycle();
        cycle();
        check_val(tag, idle, 1'b1);
    endtask

    task automatic wait_dut_draw(input string tag);
        for (int i = 0; i < 60 && !ctrl_draw; i++) cycle();
        check_val(tag, ctrl_draw, 1'b1);
    endtask

    initial begin
        cmd_t c;
        reset = 1'b0; cmd_valid = 1'b0; flush = 1'b0; vsync = 1'b0; gpu_busy = 1'b0;
        cmd_in = '0; gpu_cnt = 0; gpu_len = 0; extra_busy = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk); #1;
        reset = 1'b1;

        // single draw with a long GPU busy, strobe in the third cycle after the accepting edge
        gpu_len = 128;
        c = rand_cmd(2'd0);
        c.address = 32'h1000; c.x = XW'(10); c.y = YW'(20); c.width = XW'(16); c.height = YW'(8);
        push(c);
        cycle();
        check_val("lat_before", ctrl_draw, 1'b0);
        cycle();
        check_val("lat_strobe", ctrl_draw, 1'b1);
        check_val("lat_addr", ctrl_address, 32'h1000);
        drain("single_idle");

        // back-to-back clear then draw
        gpu_len = 10;
        n_strobes = 0;
        c = rand_cmd(2'd1);
        c.clear_color = 16'hF801;
        push(c);
        push(rand_cmd(2'd0));
        drain("b2b_idle");
        check_val("b2b_strobes", n_strobes, 2);

        // fill past capacity while the GPU stays busy
        extra_busy = 1'b1;
        gpu_len = 3;
        for (int i = 0; i < DEPTH + 1; i++) push(rand_cmd(2'($urandom_range(0, 1))));
        check_val("full_level", level, DEPTH);
        check_val("full_ready", cmd_ready, 1'b0);
        n_strobes = 0;
        extra_busy = 1'b0;
        drain("full_idle");
        check_val("full_strobes", n_strobes, DEPTH);

        // wait for vsync with vsync already high on entry
        vsync = 1'b1;
        cycle();
        n_strobes = 0;
        push(rand_cmd(2'd2));
        push(rand_cmd(2'd0));
        repeat (15) cycle();
        check_val("vs_hold", n_strobes, 0);
        vsync = 1'b0;
        repeat (2) cycle();
        vsync = 1'b1;
        cycle();
        cycle();
        check_val("vs_early", ctrl_draw, 1'b0);
        cycle();
        check_val("vs_strobe", ctrl_draw, 1'b1);
        drain("vs_idle");

        // flush five queued commands behind an in-flight draw, then a NOP
        gpu_len = 60;
        push(rand_cmd(2'd0));
        wait_dut_draw("flush_draw_seen");
        for (int i = 0; i < 5; i++) push(rand_cmd(2'($urandom_range(0, 1))));
        check_val("flush_pre_level", level, 5);
        n_strobes = 0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_val("flush_level", level, 0);
        drain("flush_idle");
        push(rand_cmd(2'd3));
        repeat (6) cycle();
        check_val("nop_strobes", n_strobes, 0);
        check_val("nop_idle", idle, 1'b1);

        // asynchronous reset while a draw strobe is high
        gpu_len = 5;
        for (int i = 0; i < 3; i++) push(rand_cmd(2'd0));
        wait_dut_draw("rst_draw_seen");
        reset = 1'b0;
        #1;
        check_val("rst_draw", ctrl_draw, 1'b0);
        check_val("rst_level", level, 0);
        check_val("rst_ready", cmd_ready, 1'b1);
        check_val("rst_addr", ctrl_address, 32'h0);
        check_val("rst_color", ctrl_clear_color, 16'h0);
        model_reset();
        gpu_cnt = 0; gpu_busy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // randomised traffic
        gpu_len = 0;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = ($urandom_range(0, 1) == 0);
            cmd_in     = rand_cmd(2'($urandom_range(0, 3)));
            flush      = ($urandom_range(0, 39) == 0);
            extra_busy = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) vsync = ~vsync;
            cycle();
        end
        cmd_valid = 1'b0; flush = 1'b0; extra_busy = 1'b0;
        for (int i = 0; i < 200 && (m_active || m_q.size() > 0 || gpu_cnt > 0); i++) begin
            if ($urandom_range(0, 3) == 0) vsync = ~vsync;
            cycle();
        end
        cycle();
        check_val("final_idle", idle, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
